// File: rtl/ibex_obi_mem.sv
// ibex_obi_mem: instr + data OBI ports sharing one single-port word RAM,
// with per-port fixed-latency response pipes and starvation-bounded arbitration.
module ibex_obi_mem #(
  parameter int unsigned MemWords       = 4096,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b1,
  parameter int unsigned StarveLimit    = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned IdxW = $clog2(MemWords);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned StvW = $clog2(StarveLimit + 2);
  localparam logic [32:0] Span = 33'(MemWords) << 2;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
  localparam logic [StvW-1:0] StvLim = StvW'(StarveLimit);

  logic [31:0] mem [MemWords];

  logic [CntW-1:0] i_cnt, d_cnt;
  logic [StvW-1:0] i_stv, d_stv;

  logic [Latency-1:0] i_vld, i_err;
  logic [Latency-1:0] d_vld, d_err;
  logic [31:0] i_dat [Latency];
  logic [31:0] d_dat [Latency];

  logic i_elig, d_elig, both;
  logic i_gnt, d_gnt;
  logic [31:0] addr, off, rd;
  logic acc_err;
  logic [IdxW-1:0] idx;

  // A slot freed by this cycle's response may be re-granted at once.
  assign i_elig = instr_req_i &&
                  (i_cnt < MaxCnt || instr_rvalid_o);
  assign d_elig = data_req_i &&
                  (d_cnt < MaxCnt || data_rvalid_o);
  assign both = i_elig && d_elig;

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_ni) begin
      if (both) begin
        if (DataPriority)
          d_gnt = (i_stv != StvLim);
        else
          d_gnt = (d_stv == StvLim);
        i_gnt = !d_gnt;
      end else begin
        i_gnt = i_elig;
        d_gnt = d_elig;
      end
    end
  end

  assign addr = d_gnt ? data_addr_i : instr_addr_i;
  assign off = addr - BaseAddr;
  assign acc_err = (addr[1:0] != 2'b00) ||
                   ({1'b0, off} >= Span);
  assign idx = off[IdxW+1:2];
  assign rd = acc_err ? 32'h0 : mem[idx];

  always_ff @(posedge clk_i) begin
    if (d_gnt && data_we_i && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b])
          mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      i_vld <= '0;
      i_err <= '0;
      d_vld <= '0;
      d_err <= '0;
      for (int k = 0; k < Latency; k++) begin
        i_dat[k] <= '0;
        d_dat[k] <= '0;
      end
    end else begin
      for (int k = Latency - 1; k > 0; k--) begin
        i_vld[k] <= i_vld[k-1];
        i_err[k] <= i_err[k-1];
        i_dat[k] <= i_dat[k-1];
        d_vld[k] <= d_vld[k-1];
        d_err[k] <= d_err[k-1];
        d_dat[k] <= d_dat[k-1];
      end
      i_vld[0] <= i_gnt;
      i_err[0] <= i_gnt && acc_err;
      i_dat[0] <= i_gnt ? rd : 32'h0;
      d_vld[0] <= d_gnt;
      d_err[0] <= d_gnt && acc_err;
      d_dat[0] <= (d_gnt && !data_we_i) ? rd : 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      i_cnt <= '0;
      d_cnt <= '0;
      i_stv <= '0;
      d_stv <= '0;
    end else begin
      i_cnt <= i_cnt + CntW'(i_gnt)
                     - CntW'(instr_rvalid_o);
      d_cnt <= d_cnt + CntW'(d_gnt)
                     - CntW'(data_rvalid_o);
      if (!instr_req_i || i_gnt)
        i_stv <= '0;
      else if (both)
        i_stv <= i_stv + StvW'(1);
      if (!data_req_i || d_gnt)
        d_stv <= '0;
      else if (both)
        d_stv <= d_stv + StvW'(1);
    end
  end

  assign instr_gnt_o    = i_gnt;
  assign instr_rvalid_o = i_vld[Latency-1];
  assign instr_rdata_o  = i_dat[Latency-1];
  assign instr_err_o    = i_err[Latency-1];
  assign data_gnt_o     = d_gnt;
  assign data_rvalid_o  = d_vld[Latency-1];
  assign data_rdata_o   = d_dat[Latency-1];
  assign data_err_o     = d_err[Latency-1];

endmodule

// File: tb/tb_ibex_obi_mem.sv
// tb_ibex_obi_mem: directed checks of access, arbitration,
// outstanding limit, error and reset behaviour.
module tb_ibex_obi_mem;

  localparam int unsigned MEMW = 64;

  logic clk;
  logic rst_n, l_rst_n;

  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;

  logic        l_i_req, l_i_gnt, l_i_rvalid, l_i_err;
  logic [31:0] l_i_addr, l_i_rdata;
  logic        l_d_req, l_d_we, l_d_gnt, l_d_rvalid, l_d_err;
  logic [3:0]  l_d_be;
  logic [31:0] l_d_addr, l_d_wdata, l_d_rdata;

  int n_chk = 0;
  int n_err = 0;

  ibex_obi_mem #(
    .MemWords(MEMW),
    .Latency(1),
    .MaxOutstanding(2),
    .DataPriority(1'b1),
    .StarveLimit(3)
  ) u_dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .instr_req_i(i_req),
    .instr_addr_i(i_addr),
    .instr_gnt_o(i_gnt),
    .instr_rvalid_o(i_rvalid),
    .instr_rdata_o(i_rdata),
    .instr_err_o(i_err),
    .data_req_i(d_req),
    .data_we_i(d_we),
    .data_be_i(d_be),
    .data_addr_i(d_addr),
    .data_wdata_i(d_wdata),
    .data_gnt_o(d_gnt),
    .data_rvalid_o(d_rvalid),
    .data_rdata_o(d_rdata),
    .data_err_o(d_err)
  );

  ibex_obi_mem #(
    .MemWords(MEMW),
    .Latency(4),
    .MaxOutstanding(2),
    .DataPriority(1'b1),
    .StarveLimit(3)
  ) u_lat (
    .clk_i(clk),
    .rst_ni(l_rst_n),
    .instr_req_i(l_i_req),
    .instr_addr_i(l_i_addr),
    .instr_gnt_o(l_i_gnt),
    .instr_rvalid_o(l_i_rvalid),
    .instr_rdata_o(l_i_rdata),
    .instr_err_o(l_i_err),
    .data_req_i(l_d_req),
    .data_we_i(l_d_we),
    .data_be_i(l_d_be),
    .data_addr_i(l_d_addr),
    .data_wdata_i(l_d_wdata),
    .data_gnt_o(l_d_gnt),
    .data_rvalid_o(l_d_rvalid),
    .data_rdata_o(l_d_rdata),
    .data_err_o(l_d_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dacc(input string tag,
                      input logic we,
                      input logic [3:0] be,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [31:0] er,
                      input logic ee);
    step();
    d_req = 1'b1;
    d_we = we;
    d_be = be;
    d_addr = a;
    d_wdata = wd;
    @(negedge clk);
    check({tag, "_gnt"}, d_gnt, 1);
    step();
    d_req = 1'b0;
    d_we = 1'b0;
    @(negedge clk);
    check({tag, "_rv"}, d_rvalid, 1);
    check({tag, "_rd"}, d_rdata, er);
    check({tag, "_err"}, d_err, ee);
  endtask

  task automatic iacc(input string tag,
                      input logic [31:0] a,
                      input logic [31:0] er,
                      input logic ee);
    step();
    i_req = 1'b1;
    i_addr = a;
    @(negedge clk);
    check({tag, "_gnt"}, i_gnt, 1);
    step();
    i_req = 1'b0;
    @(negedge clk);
    check({tag, "_rv"}, i_rvalid, 1);
    check({tag, "_rd"}, i_rdata, er);
    check({tag, "_err"}, i_err, ee);
  endtask

  initial begin
    logic prev;
    logic exp_dg, eg, erv;

    rst_n = 1'b0;
    l_rst_n = 1'b0;
    i_req = 1'b1;
    i_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_be = 4'hF;
    d_addr = '0;
    d_wdata = '0;
    l_i_req = 1'b0;
    l_i_addr = '0;
    l_d_req = 1'b0;
    l_d_we = 1'b0;
    l_d_be = 4'hF;
    l_d_addr = '0;
    l_d_wdata = '0;

    @(negedge clk);
    check("rst_gnt", i_gnt, 0);
    check("rst_rv", i_rvalid, 0);
    check("rst_rd", i_rdata, 0);
    check("rst_drv", d_rvalid, 0);
    step();
    rst_n = 1'b1;
    l_rst_n = 1'b1;
    i_req = 1'b0;

    // full write, then read back on the very next cycle
    step();
    d_req = 1'b1;
    d_we = 1'b1;
    d_be = 4'hF;
    d_addr = 32'h10;
    d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("w_gnt", d_gnt, 1);
    step();
    d_we = 1'b0;
    @(negedge clk);
    check("raw_gnt", d_gnt, 1);
    check("w_rv", d_rvalid, 1);
    check("w_rd", d_rdata, 0);
    step();
    d_req = 1'b0;
    @(negedge clk);
    check("raw_rv", d_rvalid, 1);
    check("raw_rd", d_rdata, 32'hDEAD_BEEF);
    check("raw_err", d_err, 0);

    dacc("pw", 1'b1, 4'b0010, 32'h10, 32'h0000_AA00, 32'h0, 1'b0);
    dacc("pr", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD_AAEF, 1'b0);
    dacc("bz", 1'b1, 4'h0, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
    dacc("bzr", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD_AAEF, 1'b0);

    dacc("w0", 1'b1, 4'hF, 32'h0, 32'h1122_3344, 32'h0, 1'b0);
    dacc("e3", 1'b0, 4'hF, 32'h3, 32'h0, 32'h0, 1'b1);
    dacc("eoob", 1'b0, 4'hF, 32'h100, 32'h0, 32'h0, 1'b1);
    dacc("ew3", 1'b1, 4'hF, 32'h3, 32'hFFFF_FFFF, 32'h0, 1'b1);
    dacc("r0", 1'b0, 4'hF, 32'h0, 32'h0, 32'h1122_3344, 1'b0);

    iacc("if10", 32'h10, 32'hDEAD_AAEF, 1'b0);
    iacc("ifoob", 32'h101, 32'h0, 1'b1);

    // both ports contend every cycle: D D D I repeating
    step();
    i_req = 1'b1;
    i_addr = 32'h0;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h10;
    prev = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      @(negedge clk);
      exp_dg = (k % 4) != 3;
      check("arb_dgnt", d_gnt, exp_dg);
      check("arb_ignt", i_gnt, !exp_dg);
      check("arb_irv", i_rvalid, prev);
      if (prev) check("arb_ird", i_rdata, 32'h1122_3344);
      prev = !exp_dg;
    end
    step();
    i_req = 1'b0;
    d_req = 1'b0;

    // Latency 4 instance: seed a word through the data port
    step();
    l_d_req = 1'b1;
    l_d_we = 1'b1;
    l_d_be = 4'hF;
    l_d_addr = 32'h20;
    l_d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("l_w_gnt", l_d_gnt, 1);
    step();
    l_d_req = 1'b0;
    l_d_we = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("l_w_rv", l_d_rvalid, 1);
    check("l_w_rd", l_d_rdata, 0);
    check("l_w_err", l_d_err, 0);

    // held fetch: grant, grant, stall, stall, ...
    step();
    l_i_req = 1'b1;
    l_i_addr = 32'h20;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      @(negedge clk);
      eg = (k % 4) < 2;
      erv = (k >= 4) && ((k % 4) < 2);
      check("mo_gnt", l_i_gnt, eg);
      check("mo_rv", l_i_rvalid, erv);
      if (erv) check("mo_rd", l_i_rdata, 32'hCAFE_F00D);
    end

    // reset with two fetches in flight
    step();
    l_rst_n = 1'b0;
    l_i_req = 1'b0;
    step();
    l_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      @(negedge clk);
      check("pr_rv", l_i_rvalid, 0);
      check("pr_rd", l_i_rdata, 0);
      check("pr_err", l_i_err, 0);
    end
    step();
    l_i_req = 1'b1;
    @(negedge clk);
    check("pr_gnt0", l_i_gnt, 1);
    step();
    @(negedge clk);
    check("pr_gnt1", l_i_gnt, 1);
    step();
    l_i_req = 1'b0;
    step();
    @(negedge clk);
    check("pr_rv0", l_i_rvalid, 0);
    step();
    @(negedge clk);
    check("pr_rv1", l_i_rvalid, 1);
    check("pr_rd1", l_i_rdata, 32'hCAFE_F00D);
    step();
    @(negedge clk);
    check("pr_rv2", l_i_rvalid, 1);
    check("pr_rd2", l_i_rdata, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
